// File: rtl/gate_chk_pkg.sv
// Shared types and truth-table constants for the gate truth checker.
// Truth constants are indexed by the input vector {in[1], in[0]}; bit i is
// the expected gate output for vector i.
package gate_chk_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam logic [3:0] TT_NOR  = 4'b0001;
   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/gate_truth_checker.sv
// Sweeps every input vector into a combinational gate, holds each vector for
// SETTLE+1 cycles, samples the gate output on the last edge of that window and
// compares it against TRUTH. Reports pass/fail, a mismatch count and the
// index of the first failing vector. Results hold until the next sweep.
module gate_truth_checker
   import gate_chk_pkg::*;
#(
   parameter int                    N_IN   = 2,
   parameter logic [2**N_IN-1:0]    TRUTH  = TT_NOR,
   parameter int                    SETTLE = 1,
   localparam int                   CNT_W  = N_IN + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [N_IN-1:0]   dut_in,
   input  logic              dut_out,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [CNT_W-1:0]  err_cnt,
   output logic              err_valid,
   output logic [N_IN-1:0]   first_err_idx
);

   // Settle counter only ever holds SETTLE-1, so size it for that range.
   localparam int                 SC_W     = $clog2(SETTLE + 1);
   localparam logic [SC_W-1:0]    CNT_INIT = SC_W'(SETTLE - 1);
   localparam logic [N_IN-1:0]    LAST_IDX = {N_IN{1'b1}};

   state_e              state_q;
   logic [N_IN-1:0]     idx_q;
   logic [SC_W-1:0]     cnt_q;
   logic                busy_q;
   logic                done_q;
   logic                pass_q;
   logic [CNT_W-1:0]    err_cnt_q;
   logic                err_valid_q;
   logic [N_IN-1:0]     first_err_idx_q;
   logic                mismatch_d;

   // Compare the live gate output against the expected bit for the current vector.
   always_comb begin
      mismatch_d = (dut_out != TRUTH[idx_q]);
   end

   // Sweep FSM: settle counter, vector index and all registered results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         idx_q           <= '0;
         cnt_q           <= '0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         pass_q          <= 1'b0;
         err_cnt_q       <= '0;
         err_valid_q     <= 1'b0;
         first_err_idx_q <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  idx_q           <= '0;
                  cnt_q           <= CNT_INIT;
                  err_cnt_q       <= '0;
                  err_valid_q     <= 1'b0;
                  first_err_idx_q <= '0;
                  pass_q          <= 1'b0;
                  busy_q          <= 1'b1;
                  state_q         <= WAIT;
               end
            end
            WAIT: begin
               if (cnt_q == '0) begin
                  state_q <= CHECK;
               end else begin
                  cnt_q <= cnt_q - SC_W'(1);
               end
            end
            CHECK: begin
               if (mismatch_d) begin
                  err_cnt_q <= err_cnt_q + CNT_W'(1);
                  if (!err_valid_q) begin
                     first_err_idx_q <= idx_q;
                     err_valid_q     <= 1'b1;
                  end
               end
               if (idx_q == LAST_IDX) begin
                  // Pass must account for the vector being checked right now.
                  pass_q  <= (err_cnt_q == '0) && !mismatch_d;
                  idx_q   <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  idx_q   <= idx_q + N_IN'(1);
                  cnt_q   <= CNT_INIT;
                  state_q <= WAIT;
               end
            end
            DONE: begin
               // start is deliberately ignored here; a held start re-arms from IDLE.
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign dut_in        = idx_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign pass          = pass_q;
   assign err_cnt       = err_cnt_q;
   assign err_valid     = err_valid_q;
   assign first_err_idx = first_err_idx_q;

endmodule

// File: doc/gate_truth_checker.md
Name: gate_truth_checker

Overview:
- Hardware-side counterpart of our gate truth-table stimulus: drives every input combination into a combinational gate under test, samples its output, and checks it against a parameterised truth table.
- Reports pass/fail, a mismatch count and the first failing vector index.
- Used as a self-checking harness next to NOR/NAND/AND/OR gate blocks, so gate checks run in hardware without printed tables.

Parameters:
- N_IN, 2, number of gate inputs; vectors swept 0 .. 2**N_IN-1.
- TRUTH, 4'b0001 (NOR), width 2**N_IN; bit i = expected output for input vector i, where i = {in[N_IN-1] .. in[0]}, MSB = first operand.
- SETTLE, 1, cycles a vector is held before sampling; must be >= 1.
- CNT_W, N_IN+1 (localparam), width of the error counter; holds up to 2**N_IN, so the counter never saturates.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin a sweep; sampled only in IDLE
- dut_in  output  N_IN  vector driven to the gate under test (registered)
- dut_out  input  1  gate output
- busy  output  1  high from the start-accept edge until the DONE state is entered
- done  output  1  one-cycle pulse at end of sweep
- pass  output  1  1 if the last sweep had zero mismatches; held until the next start
- err_cnt  output  CNT_W  mismatch count of the current/last sweep
- err_valid  output  1  a mismatch has been recorded in this sweep
- first_err_idx  output  N_IN  index of the first mismatching vector; valid when err_valid=1

Behaviour:
- Reset, asynchronous on rst_n low, any time: state=IDLE, and idx, cnt, dut_in, busy, done, pass, err_cnt, err_valid, first_err_idx all 0. An in-flight sweep is abandoned with no done pulse.
- dut_in = idx register; it is 0 in IDLE and DONE.
- FSM states: IDLE, WAIT, CHECK, DONE.
- IDLE, on start=1:
  - idx=0, cnt=SETTLE-1.
  - err_cnt=0, err_valid=0, first_err_idx=0, pass=0.
  - busy=1, go to WAIT.
- WAIT: if cnt==0 go to CHECK, else decrement cnt.
- CHECK (one cycle): compare dut_out with TRUTH[idx] at the clock edge.
  - On mismatch: err_cnt+1. If err_valid was 0, capture first_err_idx=idx and set err_valid=1.
  - If idx==2**N_IN-1: go to DONE, set pass = (no mismatch in the whole sweep, including this vector), idx=0, busy=0.
  - Otherwise: idx+1, cnt=SETTLE-1, go to WAIT.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Timing: each vector is applied for SETTLE+1 cycles, and dut_out is sampled on the last edge of that window.
  - Start accepted at edge T0; vector k is sampled at edge T0+(k+1)(SETTLE+1).
  - done is high between edge T0+2**N_IN(SETTLE+1) and the following edge.
  - N_IN=2, SETTLE=1: samples at T2, T4, T6, T8; done high T8..T9.
- start while busy, or in DONE: ignored, no restart. A start held high continuously begins a new sweep on the first IDLE cycle.
- Results (pass, err_cnt, err_valid, first_err_idx) hold after done until the next accepted start.

Decomposition:
- Package gate_chk_pkg:
  - state enum (IDLE, WAIT, CHECK, DONE).
  - 2-input truth constants: TT_NOR=4'b0001, TT_NAND=4'b0111, TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110.
- Single module; no sub-module needed. The settle counter and FSM stay inline.

Test Plan:
- NOR gate attached, TRUTH=TT_NOR, SETTLE=1, start pulse → dut_in = 0,0,1,1,2,2,3,3 on successive cycles; done high 8 cycles after the start edge for one cycle; pass=1, err_cnt=0, err_valid=0.
- OR gate attached, TRUTH=TT_NOR → err_cnt=4, err_valid=1, first_err_idx=0, pass=0.
- NOR model faulty only at vector 2 (outputs 1) → err_cnt=1, first_err_idx=2, pass=0. A second start then clears the results: during that run err_cnt=0 and pass=0 until the new done.
- start held high throughout, plus extra pulses mid-sweep → no restart; busy stays high; exactly one done per sweep; a back-to-back sweep begins the cycle after DONE.
- rst_n low while idx=2 → all outputs 0 immediately (asynchronous); no done. After release, start → full clean sweep, pass=1.
- Gate model with 2-cycle registered latency: SETTLE=3 → pass=1. SETTLE=1 → pass=0, err_cnt>0.
